// File: rtl/matrix_inv_pkg.sv
// Shared types and constants for the 2x2 Q16.16 matrix inverter.
package matrix_inv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 16;

    // Q16.16 reference constants (default format)
    localparam logic [31:0] Q_ONE = 32'h0001_0000;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        DET,
        DIV,
        SCALE,
        DONE
    } state_t;

endpackage

// File: rtl/matrix_inv_div.sv
// Restoring divider producing floor(2^WIDTH / divisor), one quotient bit per
// cycle. The dividend is the fixed constant 2^(2*FRAC) = 2^WIDTH, so only its
// leading bit is 1; it is injected on the go cycle and zeros follow.
// go performs the first step, valid pulses WIDTH edges later (WIDTH+1 total).
module fxp_recip_div
    import matrix_inv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   quotient,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic             r_valid;

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_rem_in;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_d      = go ? divisor : r_div;
        w_rem_in = go ? '0 : r_rem;
        w_trial  = {w_rem_in, go};
        w_ge     = (w_trial >= {1'b0, w_d});
        w_rem_nx = w_ge ? WIDTH'(w_trial - {1'b0, w_d}) : w_trial[WIDTH-1:0];
    end

    // Iteration state: quotient bits shift in at the LSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (go) begin
                r_div <= divisor;
                r_rem <= w_rem_nx;
                r_q   <= {{WIDTH{1'b0}}, w_ge};
                r_cnt <= CW'(1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_rem <= w_rem_nx;
                r_q   <= {r_q[WIDTH-1:0], w_ge};
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH)) begin
                    r_run   <= 1'b0;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_q;
    assign valid    = r_valid;

endmodule

// File: rtl/matrix_inv.sv
// Sequential 2x2 signed fixed-point inverter: C = adj(A) / det(A).
// det -> reciprocal by restoring division -> scale adjugate, with saturation.
module matrix_inv
    import matrix_inv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a11,
    input  logic [WIDTH-1:0] a12,
    input  logic [WIDTH-1:0] a21,
    input  logic [WIDTH-1:0] a22,
    output logic [WIDTH-1:0] c11,
    output logic [WIDTH-1:0] c12,
    output logic [WIDTH-1:0] c21,
    output logic [WIDTH-1:0] c22,
    output logic             done,
    output logic             busy,
    output logic             singular,
    output logic             overflow
);

    // Products carry one extra bit so -(-2^31) and the det extremes are exact
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic signed [PW:0] sx(input logic [WIDTH-1:0] x);
        return $signed({{(PW+1-WIDTH){x[WIDTH-1]}}, x});
    endfunction

    // {overflow, value}: arithmetic shift by FRAC, saturate if not WIDTH-signed
    function automatic logic [WIDTH:0] shift_sat(input logic signed [PW:0] prod);
        logic signed [PW:0] s;
        logic               fits;
        s    = prod >>> FRAC;
        fits = (&s[PW:WIDTH-1]) | ~(|s[PW:WIDTH-1]);
        if (fits) return {1'b0, s[WIDTH-1:0]};
        return {1'b1, s[PW] ? SAT_MIN : SAT_MAX};
    endfunction

    state_t r_state, w_next;

    logic [WIDTH-1:0] r_a11, r_a12, r_a21, r_a22;
    logic [WIDTH-1:0] r_recip;
    logic             r_neg;
    logic [WIDTH-1:0] r_c11, r_c12, r_c21, r_c22;
    logic             r_sing, r_ovf;

    logic signed [PW:0] w_p, w_sh;
    logic [WIDTH-1:0]   w_det, w_det_abs;
    logic               w_det_ovf, w_det_zero;
    logic               w_go;
    logic [WIDTH:0]     w_q;
    logic               w_q_vld, w_q_ovf;
    logic [WIDTH-1:0]   w_recip;
    logic [WIDTH:0]     w_s11, w_s12, w_s21, w_s22;

    // Determinant in Q32.32 and its Q16.16 truncation, plus range checks
    always_comb begin
        w_p        = sx(r_a11) * sx(r_a22) - sx(r_a12) * sx(r_a21);
        w_sh       = w_p >>> FRAC;
        w_det      = w_sh[WIDTH-1:0];
        w_det_ovf  = ~((&w_sh[PW:WIDTH-1]) | ~(|w_sh[PW:WIDTH-1]));
        w_det_zero = (w_det == '0);
        w_det_abs  = w_det[WIDTH-1] ? (~w_det + WIDTH'(1)) : w_det;
    end

    fxp_recip_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (w_go),
        .divisor  (w_det_abs),
        .quotient (w_q),
        .valid    (w_q_vld)
    );

    // Signed reciprocal and saturated adjugate scaling
    always_comb begin
        w_q_ovf = w_q[WIDTH] | w_q[WIDTH-1];
        w_recip = r_neg ? (~w_q[WIDTH-1:0] + WIDTH'(1)) : w_q[WIDTH-1:0];
        w_s11   = shift_sat(sx(r_a22) * sx(r_recip));
        w_s12   = shift_sat(-sx(r_a12) * sx(r_recip));
        w_s21   = shift_sat(-sx(r_a21) * sx(r_recip));
        w_s22   = shift_sat(sx(r_a11) * sx(r_recip));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; the divider is launched on the DET exit to DIV
    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = DET;
            DET: begin
                if (w_det_ovf || w_det_zero) begin
                    w_next = DONE;
                end else begin
                    w_next = DIV;
                    w_go   = 1'b1;
                end
            end
            DIV:   if (w_q_vld) w_next = w_q_ovf ? DONE : SCALE;
            SCALE: w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, status flags and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a11   <= '0;
            r_a12   <= '0;
            r_a21   <= '0;
            r_a22   <= '0;
            r_recip <= '0;
            r_neg   <= 1'b0;
            r_c11   <= '0;
            r_c12   <= '0;
            r_c21   <= '0;
            r_c22   <= '0;
            r_sing  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a11  <= a11;
                        r_a12  <= a12;
                        r_a21  <= a21;
                        r_a22  <= a22;
                        r_sing <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                DET: begin
                    r_neg <= w_det[WIDTH-1];
                    if (w_det_ovf || w_det_zero) begin
                        r_ovf  <= w_det_ovf;
                        r_sing <= ~w_det_ovf;
                        r_c11  <= '0;
                        r_c12  <= '0;
                        r_c21  <= '0;
                        r_c22  <= '0;
                    end
                end
                DIV: begin
                    if (w_q_vld) begin
                        if (w_q_ovf) begin
                            r_ovf <= 1'b1;
                            r_c11 <= '0;
                            r_c12 <= '0;
                            r_c21 <= '0;
                            r_c22 <= '0;
                        end else begin
                            r_recip <= w_recip;
                        end
                    end
                end
                SCALE: begin
                    r_c11 <= w_s11[WIDTH-1:0];
                    r_c12 <= w_s12[WIDTH-1:0];
                    r_c21 <= w_s21[WIDTH-1:0];
                    r_c22 <= w_s22[WIDTH-1:0];
                    r_ovf <= w_s11[WIDTH] | w_s12[WIDTH] | w_s21[WIDTH] | w_s22[WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign c11      = r_c11;
    assign c12      = r_c12;
    assign c21      = r_c21;
    assign c22      = r_c22;
    assign singular = r_sing;
    assign overflow = r_ovf;
    assign done     = (r_state == DONE);
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_matrix_inv.sv
// Directed bench for matrix_inv: arithmetic reference model, per-cycle checker.
module tb_matrix_inv;
    import matrix_inv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a11 = '0, a12 = '0, a21 = '0, a22 = '0;
    logic [31:0] c11, c12, c21, c22;
    logic        done, busy, singular, overflow;

    matrix_inv #(.WIDTH(32), .FRAC(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .done(done), .busy(busy), .singular(singular), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expectation for the operation in flight (written by the driver)
    logic [31:0] exp_c [4];
    logic        exp_s, exp_o;
    int          exp_lat;
    int          arm_cnt = 0, abort_cnt = 0;

    // checker-owned state
    logic [31:0] held_c [4] = '{default: '0};
    logic        held_s = 1'b0, held_o = 1'b0;
    logic [31:0] cap_c [4] = '{default: '0};
    logic        pending = 1'b0;
    int          edges = 0, fin_cnt = 0, seen_arm = 0, seen_abort = 0;
    logic [31:0] dut_c [4];

    always_comb begin
        dut_c[0] = c11;
        dut_c[1] = c12;
        dut_c[2] = c21;
        dut_c[3] = c22;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: C = adj(A)/det(A) with the truncation/saturation rules
    task automatic model(input logic signed [31:0] x11, input logic signed [31:0] x12,
                         input logic signed [31:0] x21, input logic signed [31:0] x22);
        longint p, det, absd, q, recip, e;
        longint x [4];
        p = longint'(x11) * longint'(x22) - longint'(x12) * longint'(x21);
        exp_s = 1'b0;
        exp_o = 1'b0;
        for (int i = 0; i < 4; i++) exp_c[i] = '0;
        if (p >= (longint'(1) <<< 47) || p < -(longint'(1) <<< 47)) begin
            exp_o = 1'b1; exp_lat = 2;
        end else begin
            det = p >>> 16;
            if (det == 0) begin
                exp_s = 1'b1; exp_lat = 2;
            end else begin
                absd = (det < 0) ? -det : det;
                q = (longint'(1) <<< 32) / absd;
                if (q > longint'(32'h7FFF_FFFF)) begin
                    exp_o = 1'b1; exp_lat = 35;
                end else begin
                    recip = (det < 0) ? -q : q;
                    x[0] = longint'(x22);
                    x[1] = -longint'(x12);
                    x[2] = -longint'(x21);
                    x[3] = longint'(x11);
                    for (int i = 0; i < 4; i++) begin
                        e = (x[i] * recip) >>> 16;
                        if (e > longint'(32'h7FFF_FFFF)) begin
                            exp_c[i] = Q_MAX; exp_o = 1'b1;
                        end else if (e < -(longint'(1) <<< 31)) begin
                            exp_c[i] = Q_MIN; exp_o = 1'b1;
                        end else begin
                            exp_c[i] = e[31:0];
                        end
                    end
                    exp_lat = 36;
                end
            end
        end
    endtask

    function automatic logic [31:0] qdot(input logic signed [31:0] p, input logic signed [31:0] q,
                                         input logic signed [31:0] r, input logic signed [31:0] s);
        longint t;
        t = longint'(p) * longint'(q) + longint'(r) * longint'(s);
        t = t >>> 16;
        return t[31:0];
    endfunction

    // Per-cycle checker, sampling on the falling edge
    always @(negedge clk) begin
        if (abort_cnt != seen_abort) begin
            seen_abort = abort_cnt;
            pending = 1'b0;
            held_c = '{default: '0};
            held_s = 1'b0;
            held_o = 1'b0;
        end
        if (arm_cnt != seen_arm) begin
            seen_arm = arm_cnt;
            pending = 1'b1;
            edges = 1;
        end
        if (pending) begin
            chk("busy_active", {31'b0, busy}, 32'd1);
            if (done) begin
                chk("latency", edges, exp_lat);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("c%0d_result", i), dut_c[i], exp_c[i]);
                    held_c[i] = exp_c[i];
                    cap_c[i]  = dut_c[i];
                end
                chk("singular", {31'b0, singular}, {31'b0, exp_s});
                chk("overflow", {31'b0, overflow}, {31'b0, exp_o});
                held_s = exp_s;
                held_o = exp_o;
                pending = 1'b0;
                fin_cnt++;
            end else begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("c%0d_hold_busy", i), dut_c[i], held_c[i]);
                edges++;
                if (edges > exp_lat + 4) begin
                    chk("done_timeout", edges, exp_lat);
                    pending = 1'b0;
                    fin_cnt++;
                end
            end
        end else begin
            chk("done_idle", {31'b0, done}, 32'd0);
            chk("busy_idle", {31'b0, busy}, 32'd0);
            chk("singular_held", {31'b0, singular}, {31'b0, held_s});
            chk("overflow_held", {31'b0, overflow}, {31'b0, held_o});
            for (int i = 0; i < 4; i++)
                chk($sformatf("c%0d_held", i), dut_c[i], held_c[i]);
        end
    end

    // Launch one operation; optional extra start pulse or reset after k edges
    task automatic run_op(input logic [31:0] x11, input logic [31:0] x12,
                          input logic [31:0] x21, input logic [31:0] x22,
                          input int poke_at, input int rst_at);
        int target;
        model(x11, x12, x21, x22);
        @(posedge clk); #2;
        a11 = x11; a12 = x12; a21 = x21; a22 = x22;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        target = fin_cnt + 1;
        arm_cnt++;
        for (int k = 1; k < 100; k++) begin
            if (fin_cnt == target) break;
            if (k == poke_at) begin
                start = 1'b1;
                a11 = 32'h0003_0000; a12 = 32'h0001_0000;
                a21 = 32'h0001_0000; a22 = 32'h0001_0000;
            end
            if (k == poke_at + 1) start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                abort_cnt++;
            end
            @(posedge clk); #2;
            if (rst) begin
                rst = 1'b0;
                break;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // model pins against hand-computed values
        model(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
        chk("pin_c11", exp_c[0], 32'hFFFE_0000);
        chk("pin_c12", exp_c[1], 32'h0001_0000);
        chk("pin_c21", exp_c[2], 32'h0001_8000);
        chk("pin_c22", exp_c[3], 32'hFFFF_8000);
        chk("pin_lat", exp_lat, 36);
        model(32'h0000_0100, 32'h0, 32'h0, 32'h0000_0100);
        chk("pin_divovf", {31'b0, exp_o}, 32'd1);
        chk("pin_divlat", exp_lat, 35);
        model(32'h0010_0000, 32'h0010_0000, 32'h000F_FFFF, 32'h0010_0000);
        chk("pin_sat11", exp_c[0], 32'h7FFF_FFFF);
        chk("pin_sat12", exp_c[1], 32'h8000_0000);
        chk("pin_sat21", exp_c[2], 32'h8000_0000);

        // [[1,2],[3,4]]
        run_op(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 0, 0);
        chk("t1_c11_lit", cap_c[0], 32'hFFFE_0000);

        // [[5,6],[7,8]] and round trip A * C == I
        run_op(32'h0005_0000, 32'h0006_0000, 32'h0007_0000, 32'h0008_0000, 0, 0);
        chk("rt_i11", qdot(32'h0005_0000, cap_c[0], 32'h0006_0000, cap_c[2]), Q_ONE);
        chk("rt_i12", qdot(32'h0005_0000, cap_c[1], 32'h0006_0000, cap_c[3]), 32'h0);
        chk("rt_i21", qdot(32'h0007_0000, cap_c[0], 32'h0008_0000, cap_c[2]), 32'h0);
        chk("rt_i22", qdot(32'h0007_0000, cap_c[1], 32'h0008_0000, cap_c[3]), Q_ONE);

        // singular [[1,2],[2,4]]
        run_op(32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 32'h0004_0000, 0, 0);
        // reciprocal overflow: det = 1 LSB
        run_op(32'h0000_0100, 32'h0, 32'h0, 32'h0000_0100, 0, 0);
        // det out of range
        run_op(32'h7FFF_0000, 32'h0, 32'h0, 32'h7FFF_0000, 0, 0);
        // output saturation
        run_op(32'h0010_0000, 32'h0010_0000, 32'h000F_FFFF, 32'h0010_0000, 0, 0);
        // start during DIV ignored
        run_op(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 10, 0);
        // reset during DIV aborts; no done afterwards
        run_op(32'h0005_0000, 32'h0006_0000, 32'h0007_0000, 32'h0008_0000, 0, 15);
        repeat (40) @(posedge clk);
        // identity after abort
        run_op(Q_ONE, 32'h0, 32'h0, Q_ONE, 0, 0);
        chk("id_c11_lit", cap_c[0], Q_ONE);
        chk("id_c12_lit", cap_c[1], 32'h0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
